// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants and helpers: default 640x480@60 timings,
// frame totals and sync-window boundaries for the generator, renderer and models.
package vga_timing_gen_pkg;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CNT_W    = 10;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Sync is active on the half-open window [sync_start, sync_stop).
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_stop(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_clock_divider.sv
// Pixel-rate tick generator: counts enabled system clocks and strobes tick on
// the last one of every CLK_DIV; the phase is kept while enable is low.
module pixel_clock_divider
    import vga_timing_gen_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clock,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;

    always_comb begin
        div_next = div_reg;
        if (enable) begin
            div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_next;
        end
    end

    assign tick = enable && (div_reg == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel counters plus registered sync,
// blanking, strobe and snake-cell decode, all aligned with the presented counts.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   CLK_DIV    = DEF_CLK_DIV,
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   CNT_W      = DEF_CNT_W,
    parameter int   CELL_SHIFT = 4
) (
    input  logic                        clock,
    input  logic                        clear,
    input  logic                        enable,
    output logic                        hSync,
    output logic                        vSync,
    output logic                        bright,
    output logic [CNT_W-1:0]            hCount,
    output logic [CNT_W-1:0]            vCount,
    output logic                        pixelTick,
    output logic                        lineStart,
    output logic                        frameStart,
    output logic [CNT_W-CELL_SHIFT-1:0] cellX,
    output logic [CNT_W-CELL_SHIFT-1:0] cellY
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(sync_start(H_ACTIVE, H_FP));
    localparam logic [CNT_W-1:0] HS_STOP  = CNT_W'(sync_stop(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(sync_start(V_ACTIVE, V_FP));
    localparam logic [CNT_W-1:0] VS_STOP  = CNT_W'(sync_stop(V_ACTIVE, V_FP, V_SYNC));

    logic             tick;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             hsync_next;
    logic             vsync_next;
    logic             bright_next;
    logic             line_next;
    logic             frame_next;

    pixel_clock_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clock   (clock),
        .clear   (clear),
        .enable  (enable),
        .tick    (tick)
    );

    // Decode is taken from the next-state counts so registered outputs line up
    // with the counts they describe.
    always_comb begin
        h_next = hCount;
        v_next = vCount;
        if (tick) begin
            if (hCount == H_LAST) begin
                h_next = '0;
                v_next = (vCount == V_LAST) ? '0 : vCount + CNT_W'(1);
            end else begin
                h_next = hCount + CNT_W'(1);
            end
        end
        hsync_next  = ((h_next >= HS_START) && (h_next < HS_STOP)) ? HS_POL : ~HS_POL;
        vsync_next  = ((v_next >= VS_START) && (v_next < VS_STOP)) ? VS_POL : ~VS_POL;
        bright_next = (h_next < H_VIS) && (v_next < V_VIS);
        line_next   = tick && (h_next == '0);
        frame_next  = line_next && (v_next == '0);
    end

    // Reset parks the counts on the last pixel so the first tick opens a full frame.
    always_ff @(posedge clock) begin
        if (!clear) begin
            hCount     <= H_LAST;
            vCount     <= V_LAST;
            hSync      <= ~HS_POL;
            vSync      <= ~VS_POL;
            bright     <= 1'b0;
            pixelTick  <= 1'b0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
            cellX      <= H_LAST[CNT_W-1:CELL_SHIFT];
            cellY      <= V_LAST[CNT_W-1:CELL_SHIFT];
        end else begin
            hCount     <= h_next;
            vCount     <= v_next;
            hSync      <= hsync_next;
            vSync      <= vsync_next;
            bright     <= bright_next;
            pixelTick  <= tick;
            lineStart  <= line_next;
            frameStart <= frame_next;
            cellX      <= h_next[CNT_W-1:CELL_SHIFT];
            cellY      <= v_next[CNT_W-1:CELL_SHIFT];
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-size builds driven by directed steps,
// with a per-clock scoreboard from a position-index model plus period checks.
module tb_vga_timing_gen;

    logic clk100MHz = 1'b0;
    always #5 clk100MHz = ~clk100MHz;

    // Build A: CLK_DIV=4, 80x27 frame. Build B: CLK_DIV=1, HS_POL=1, CELL_SHIFT=5, 16-pixel timings.
    logic       clear_a = 1'b0, enable_a = 1'b0;
    logic       hs_a, vs_a, br_a, pt_a, ls_a, fs_a;
    logic [9:0] hc_a, vc_a;
    logic [5:0] cx_a, cy_a;
    logic       clear_b = 1'b0, enable_b = 1'b0;
    logic       hs_b, vs_b, br_b, pt_b, ls_b, fs_b;
    logic [9:0] hc_b, vc_b;
    logic [4:0] cx_b, cy_b;

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(10), .CELL_SHIFT(4)
    ) dut_a (
        .clock(clk100MHz), .clear(clear_a), .enable(enable_a),
        .hSync(hs_a), .vSync(vs_a), .bright(br_a), .hCount(hc_a), .vCount(vc_a),
        .pixelTick(pt_a), .lineStart(ls_a), .frameStart(fs_a), .cellX(cx_a), .cellY(cy_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(64), .H_FP(16), .H_SYNC(16), .H_BP(16),
        .V_ACTIVE(16), .V_FP(16), .V_SYNC(16), .V_BP(16),
        .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(10), .CELL_SHIFT(5)
    ) dut_b (
        .clock(clk100MHz), .clear(clear_b), .enable(enable_b),
        .hSync(hs_b), .vSync(vs_b), .bright(br_b), .hCount(hc_b), .vCount(vc_b),
        .pixelTick(pt_b), .lineStart(ls_b), .frameStart(fs_b), .cellX(cx_b), .cellY(cy_b)
    );

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic [9:0] cx;
        logic [9:0] cy;
        logic       bright;
        logic       hs;
        logic       vs;
        logic       pt;
        logic       ls;
        logic       fs;
    } obs_t;

    int   cdiv [2] = '{4, 1};
    int   ha   [2] = '{64, 64};
    int   hfp  [2] = '{4, 16};
    int   hsw  [2] = '{8, 16};
    int   hbp  [2] = '{4, 16};
    int   va   [2] = '{20, 16};
    int   vfp  [2] = '{2, 16};
    int   vsw  [2] = '{2, 16};
    int   vbp  [2] = '{3, 16};
    logic hpol [2] = '{1'b0, 1'b1};
    logic vpol [2] = '{1'b0, 1'b0};
    int   csh  [2] = '{4, 5};

    int     ph [2];
    longint nt [2];
    obs_t   exp_q[$];
    obs_t   last;
    int     checks = 0;
    int     fails  = 0;
    int     cyc    = 0;

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) begin
            o = '{h: hc_a, v: vc_a, cx: 10'(cx_a), cy: 10'(cy_a), bright: br_a,
                  hs: hs_a, vs: vs_a, pt: pt_a, ls: ls_a, fs: fs_a};
        end else begin
            o = '{h: hc_b, v: vc_b, cx: 10'(cx_b), cy: 10'(cy_b), bright: br_b,
                  hs: hs_b, vs: vs_b, pt: pt_b, ls: ls_b, fs: fs_b};
        end
        return o;
    endfunction

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, observed, expected);
        end
    endtask

    // One clock: drive inputs, push the model's prediction, compare after the edge.
    task automatic step(input int sel, input logic clr, input logic en, input string tag);
        obs_t e;
        int   ht, vt, f, p, h, v;
        bit   tk;
        if (sel == 0) begin
            clear_a = clr; enable_a = en;
        end else begin
            clear_b = clr; enable_b = en;
        end
        tk = 1'b0;
        if (!clr) begin
            ph[sel] = 0;
            nt[sel] = 0;
        end else if (en) begin
            tk = (ph[sel] == cdiv[sel] - 1);
            ph[sel] = (ph[sel] + 1) % cdiv[sel];
            if (tk) nt[sel]++;
        end
        ht = ha[sel] + hfp[sel] + hsw[sel] + hbp[sel];
        vt = va[sel] + vfp[sel] + vsw[sel] + vbp[sel];
        f  = ht * vt;
        p  = int'((nt[sel] + longint'(f) - 1) % longint'(f));
        h  = p % ht;
        v  = p / ht;
        e.h      = 10'(h);
        e.v      = 10'(v);
        e.cx     = 10'(h >> csh[sel]);
        e.cy     = 10'(v >> csh[sel]);
        e.bright = (h < ha[sel]) && (v < va[sel]);
        e.hs     = (h >= ha[sel] + hfp[sel] && h < ha[sel] + hfp[sel] + hsw[sel]) ? hpol[sel] : ~hpol[sel];
        e.vs     = (v >= va[sel] + vfp[sel] && v < va[sel] + vfp[sel] + vsw[sel]) ? vpol[sel] : ~vpol[sel];
        e.pt     = tk;
        e.ls     = tk && (h == 0);
        e.fs     = tk && (p == 0);
        exp_q.push_back(e);
        @(posedge clk100MHz);
        #1;
        cyc++;
        last = sample(sel);
        e = exp_q.pop_front();
        checks++;
        assert (last === e) else begin
            fails++;
            $error("FAIL %s: observed %h required %h (cycle %0d)", tag, last, e, cyc);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, t_fs, lper, fper, vlines, bpix, hs_cnt, cx95;
        bit found;

        // Build A: reset, then first tick latency
        repeat (3) step(0, 1'b0, 1'b1, "reset_a");
        chk("reset_h", int'(last.h), 79);
        chk("reset_v", int'(last.v), 26);
        k = 0;
        do begin step(0, 1'b1, 1'b1, "release_a"); k++; end while (!last.pt && k < 20);
        chk("first_tick_latency", k, 4);
        chk("first_tick_fs_ls_bright", int'({last.fs, last.ls, last.bright}), 7);

        // One full frame: line period, frame period, vsync lines, visible pixel count
        t_fs = cyc; lper = -1; fper = -1; vlines = 0; bpix = 1; k = 0;
        while (fper < 0 && k < 20000) begin
            step(0, 1'b1, 1'b1, "frame_a");
            k++;
            if (last.pt && last.bright && !last.fs) bpix++;
            if (last.ls && !last.vs) vlines++;
            if (last.ls && lper < 0) lper = cyc - t_fs;
            if (last.fs) fper = cyc - t_fs;
        end
        chk("line_period", lper, 320);
        chk("frame_period", fper, 8640);
        chk("vsync_lines", vlines, 2);
        chk("bright_pixels", bpix, 1280);

        // Freeze mid-line at hCount=50
        found = 1'b0; k = 0;
        while (!found && k < 400) begin
            step(0, 1'b1, 1'b1, "seek_freeze_a");
            k++;
            found = last.pt && (last.h == 10'd50);
        end
        chk("freeze_point_found", int'(found), 1);
        repeat (7) step(0, 1'b1, 1'b0, "freeze_a");
        k = 0;
        do begin step(0, 1'b1, 1'b1, "resume_a"); k++; end while (!last.pt && k < 10);
        chk("resume_latency", k, 4);
        chk("resume_h", int'(last.h), 51);

        // Reset mid-frame at (30,10) with divider phase 2
        found = 1'b0; k = 0;
        while (!found && k < 9000) begin
            step(0, 1'b1, 1'b1, "seek_clear_a");
            k++;
            found = last.pt && (last.h == 10'd30) && (last.v == 10'd10);
        end
        chk("clear_point_found", int'(found), 1);
        repeat (2) step(0, 1'b1, 1'b1, "phase_a");
        step(0, 1'b0, 1'b1, "midclear_a");
        chk("midclear_counts", int'({last.h, last.v}), (79 << 10) | 26);
        chk("midclear_levels", int'({last.bright, last.hs, last.vs}), 3);
        k = 0;
        do begin step(0, 1'b1, 1'b1, "rerelease_a"); k++; end while (!last.pt && k < 20);
        chk("rerelease_latency", k, 4);
        chk("rerelease_fs", int'(last.fs), 1);

        // Build B: tick every clock, positive hsync, 32-pixel cells
        repeat (2) step(1, 1'b0, 1'b1, "reset_b");
        step(1, 1'b1, 1'b1, "release_b");
        chk("b_first_fs", int'(last.fs), 1);
        t_fs = cyc; k = 1; hs_cnt = 0; cx95 = -1;
        repeat (99) begin
            step(1, 1'b1, 1'b1, "ticks_b");
            if (last.pt) k++;
        end
        chk("b_tick_every_clock", k, 100);
        repeat (112) begin
            step(1, 1'b1, 1'b1, "line_b");
            if (last.hs) hs_cnt++;
            if (last.h == 10'd95) cx95 = int'(last.cx);
        end
        chk("b_hsync_high_pixels", hs_cnt, 16);
        chk("b_cellx_at_95", cx95, 2);
        fper = -1; k = 0;
        while (fper < 0 && k < 8000) begin
            step(1, 1'b1, 1'b1, "frame_b");
            k++;
            if (last.fs) fper = cyc - t_fs;
        end
        chk("b_frame_period", fper, 7168);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator that replaces the fixed 640x480 controller in the snake display path. It divides the system clock into a pixel-rate tick, runs the horizontal and vertical counters, and decodes sync, blanking, line/frame strobes and snake-grid cell coordinates. Downstream, the game renderer consumes `bright`, the counts and the cell indices. The VGA pins consume `hSync`/`vSync`.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel (100 MHz -> 25 MHz); must be >= 1.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch; must be > 0.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch; must be > 0.
- `HS_POL`, 0: active level of `hSync`.
- `VS_POL`, 0: active level of `vSync`.
- `CNT_W`, 10: counter width; must hold H_TOTAL-1 and V_TOTAL-1.
- `CELL_SHIFT`, 4: log2 of the snake cell size in pixels.

Ports:
- `clock`  in  1  system clock; all logic is on the rising edge.
- `clear`  in  1  reset, synchronous and active-low.
- `enable`  in  1  run when high; freezes all state when low.
- `hSync`  out  1  horizontal sync, level per `HS_POL`.
- `vSync`  out  1  vertical sync, level per `VS_POL`.
- `bright`  out  1  high inside the visible area.
- `hCount`  out  CNT_W  current pixel column.
- `vCount`  out  CNT_W  current line.
- `pixelTick`  out  1  one-clock strobe when the counters advance.
- `lineStart`  out  1  one-clock strobe when `hCount` becomes 0.
- `frameStart`  out  1  one-clock strobe when the counters become (0,0).
- `cellX`  out  CNT_W-CELL_SHIFT  `hCount >> CELL_SHIFT`.
- `cellY`  out  CNT_W-CELL_SHIFT  `vCount >> CELL_SHIFT`.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Divider `div` counts 0..CLK_DIV-1 while `enable` is high.
  - Tick condition: `enable && div == CLK_DIV-1`; the divider then wraps to 0.
  - With CLK_DIV=1, every enabled clock is a tick.
- On a tick, `hCount` increments. At H_TOTAL-1 it wraps to 0 and `vCount` increments. `vCount` wraps from V_TOTAL-1 to 0.
- `hSync` is active iff H_ACTIVE+H_FP <= hCount < H_ACTIVE+H_FP+H_SYNC; otherwise it is at the inactive level `~HS_POL`.
- `vSync` is active iff V_ACTIVE+V_FP <= vCount < V_ACTIVE+V_FP+V_SYNC; it is judged on `vCount` only.
- `bright` = (hCount < H_ACTIVE) && (vCount < V_ACTIVE).
- `cellX`/`cellY` are truncating shifts. No range clamp is applied: the renderer gates them with `bright`.
- All outputs are registers. They are computed from the next-state counts, so every output always corresponds to the `hCount`/`vCount` presented in the same cycle.
- `enable` low: divider, counts and decoded outputs hold; all strobes are 0.
- Reset (`clear` low at a clock edge) has priority over `enable`:
  - `div`=0, `hCount`=H_TOTAL-1, `vCount`=V_TOTAL-1.
  - `bright`=0, `hSync`=~HS_POL, `vSync`=~VS_POL.
  - All strobes 0; `cellX`/`cellY` equal the shifts of the reset counts.
  - The first tick after reset therefore lands on (0,0) with `frameStart`, so no partial first frame is produced.
- A reset asserted mid-frame takes effect at the next edge regardless of divider phase.

## Timing
- Counter update latency is one clock after the tick condition. `pixelTick`, `lineStart` and `frameStart` are high in the same cycle the new counts appear.
- When `frameStart` is high, `lineStart` and `pixelTick` are also high.
- Tick period is exactly CLK_DIV clocks while enabled.
- `enable` toggling preserves divider phase; there is no extra or lost tick.
- Default frame length is 800*525*4 = 1,680,000 clocks.

## Structure
- A shared package holds:
  - the default 640x480@60 timing constants;
  - H_TOTAL/V_TOTAL computation functions;
  - sync-window boundaries, for reuse by the renderer and the bench model.
- One natural sub-module: `pixel_clock_divider`. It holds the `div` counter and tick generation, parameter CLK_DIV, with ports clock/clear/enable/tick. The counters and decode stay in the top module.

## Test plan
- Release reset with enable=1 and defaults:
  - first `pixelTick` occurs 4 clocks after release, with (hCount,vCount)=(0,0) and `frameStart`=`lineStart`=1;
  - `bright`=1 on that cycle.
- Run one line:
  - `bright` falls when hCount=640;
  - `hSync` is 0 for hCount 656..751 and 1 at hCount=752;
  - `lineStart` recurs every 3200 clocks.
- Run one full frame:
  - `vSync` is 0 exactly for vCount 490..491;
  - `frameStart` recurs every 1,680,000 clocks;
  - vCount reaches 524 and then 0.
- Hold enable low for 7 clocks mid-line at hCount=100: counts, `div` and outputs are frozen with no strobes; the next tick arrives with its original phase and hCount=101.
- Assert `clear` at hCount=300, vCount=200, `div`=2: the next cycle shows (799,524), `bright`=0, syncs inactive; the first tick after release is (0,0).
- Build with CLK_DIV=1, HS_POL=1, CELL_SHIFT=5 and 16-pixel timings: a tick every clock, `hSync` high only inside its window, and `cellX`=hCount>>5 (hCount=95 -> cellX=2).
